// File: rtl/sens_hispi_dly_seq_pkg.sv
// Shared command codes and sequencer state encoding for the HiSPi delay/phase sequencer.
package sens_hispi_dly_seq_pkg;

  localparam logic [2:0] CMD_LANE0    = 3'd0;
  localparam logic [2:0] CMD_LANE1    = 3'd1;
  localparam logic [2:0] CMD_LANE2    = 3'd2;
  localparam logic [2:0] CMD_LANE3    = 3'd3;
  localparam logic [2:0] CMD_PHASE    = 3'd4;
  localparam logic [2:0] CMD_MMCM_RST = 3'd5;
  localparam logic [2:0] CMD_CLR_ERR  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LN_SET  = 3'd1,
    ST_LN_LD   = 3'd2,
    ST_PH_SET  = 3'd3,
    ST_PH_WAIT = 3'd4,
    ST_MM_RST  = 3'd5,
    ST_MM_LOCK = 3'd6
  } state_t;

  function automatic logic is_lane_cmd(input logic [2:0] addr);
    return (addr <= CMD_LANE3);
  endfunction

endpackage

// File: rtl/sens_hispi_dly_seq.sv
// Coalesces software delay/phase/MMCM-reset requests and replays them one at a time
// over the shared dly_data bus towards the HiSPi receiver.
module sens_hispi_dly_seq
  import sens_hispi_dly_seq_pkg::*;
#(
  parameter int HISPI_NUMLANES = 4,
  parameter int RST_CYCLES     = 16,
  parameter int PS_MIN         = 4,
  parameter int TMO_WIDTH      = 16,
  parameter int PS_TIMEOUT     = 1000,
  parameter int LOCK_TIMEOUT   = 50000
) (
  input  logic                        i_mclk,
  input  logic                        i_mrst_n,
  input  logic                        i_cmd_we,
  input  logic [2:0]                  i_cmd_addr,
  input  logic [7:0]                  i_cmd_data,
  input  logic                        i_ps_rdy,
  input  logic                        i_locked,
  output logic [HISPI_NUMLANES*8-1:0] o_dly_data,
  output logic [HISPI_NUMLANES-1:0]   o_set_idelay,
  output logic                        o_ld_idelay,
  output logic                        o_set_clk_phase,
  output logic                        o_rst_mmcm,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [HISPI_NUMLANES+1:0]   o_pending,
  output logic                        o_err_ps_tmo,
  output logic                        o_err_lock_tmo,
  output state_t                      o_state
);

  localparam int NL = HISPI_NUMLANES;
  localparam logic [TMO_WIDTH-1:0] C_RST_LAST  = TMO_WIDTH'(RST_CYCLES - 1);
  localparam logic [TMO_WIDTH-1:0] C_PS_MIN    = TMO_WIDTH'(PS_MIN);
  localparam logic [TMO_WIDTH-1:0] C_PS_LAST   = TMO_WIDTH'(PS_TIMEOUT - 1);
  localparam logic [TMO_WIDTH-1:0] C_LOCK_LAST = TMO_WIDTH'(LOCK_TIMEOUT - 1);

  // Valid/ready: a command is accepted on every clock where i_cmd_we=1 (always ready);
  // receiver-side strobes are single-cycle and never back-pressured.

  state_t               r_state;
  logic [TMO_WIDTH-1:0] r_cnt;
  logic [NL*8-1:0]      r_lane_shadow;
  logic [7:0]           r_ph_shadow;
  logic [NL-1:0]        r_pend_lane;
  logic                 r_pend_ph;
  logic                 r_pend_mmcm;
  logic [NL*8-1:0]      r_dly_data;
  logic [NL-1:0]        r_set_idelay;
  logic                 r_ld_idelay;
  logic                 r_set_clk_phase;
  logic                 r_rst_mmcm;
  logic                 r_done;
  logic                 r_err_ps_tmo;
  logic                 r_err_lock_tmo;

  logic [NL-1:0]        w_lane_we;
  logic [NL*8-1:0]      w_ph_dly;
  logic                 w_ph_we;
  logic                 w_mmcm_we;
  logic                 w_clr_we;

  function automatic logic [TMO_WIDTH-1:0] sat_inc(input logic [TMO_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    w_lane_we = '0;
    for (int i = 0; i < NL; i++) begin
      if (i_cmd_we && is_lane_cmd(i_cmd_addr) && (i_cmd_addr == 3'(i))) w_lane_we[i] = 1'b1;
    end
    w_ph_we   = i_cmd_we && (i_cmd_addr == CMD_PHASE);
    w_mmcm_we = i_cmd_we && (i_cmd_addr == CMD_MMCM_RST);
    w_clr_we  = i_cmd_we && (i_cmd_addr == CMD_CLR_ERR);
    // Phase shares byte 0 with lane 0; upper lanes keep their shadows.
    w_ph_dly       = r_lane_shadow;
    w_ph_dly[7:0]  = r_ph_shadow;
  end

  // Statement order matters: FSM clears come before the command-write sets so a
  // same-cycle write keeps its pending bit, and the error clear precedes error sets.
  always_ff @(posedge i_mclk or negedge i_mrst_n) begin
    if (!i_mrst_n) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_lane_shadow   <= '0;
      r_ph_shadow     <= '0;
      r_pend_lane     <= '0;
      r_pend_ph       <= 1'b0;
      r_pend_mmcm     <= 1'b0;
      r_dly_data      <= '0;
      r_set_idelay    <= '0;
      r_ld_idelay     <= 1'b0;
      r_set_clk_phase <= 1'b0;
      r_rst_mmcm      <= 1'b0;
      r_done          <= 1'b0;
      r_err_ps_tmo    <= 1'b0;
      r_err_lock_tmo  <= 1'b0;
    end else begin
      r_set_idelay    <= '0;
      r_ld_idelay     <= 1'b0;
      r_set_clk_phase <= 1'b0;
      r_done          <= 1'b0;

      if (w_clr_we) begin
        r_err_ps_tmo   <= 1'b0;
        r_err_lock_tmo <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (r_pend_mmcm) begin
            r_pend_mmcm <= 1'b0;
            r_rst_mmcm  <= 1'b1;
            r_state     <= ST_MM_RST;
          end else if (r_pend_ph && i_locked) begin
            r_state <= ST_PH_SET;
          end else if (|r_pend_lane) begin
            r_state <= ST_LN_SET;
          end
        end
        ST_LN_SET: begin
          r_dly_data   <= r_lane_shadow;
          r_set_idelay <= r_pend_lane;
          r_pend_lane  <= '0;
          r_state      <= ST_LN_LD;
        end
        ST_LN_LD: begin
          r_ld_idelay <= 1'b1;
          r_done      <= 1'b1;
          r_state     <= ST_IDLE;
        end
        ST_PH_SET: begin
          r_dly_data      <= w_ph_dly;
          r_set_clk_phase <= 1'b1;
          r_pend_ph       <= 1'b0;
          r_cnt           <= '0;
          r_state         <= ST_PH_WAIT;
        end
        ST_PH_WAIT: begin
          if ((r_cnt >= C_PS_MIN) && i_ps_rdy) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (r_cnt >= C_PS_LAST) begin
            r_err_ps_tmo <= 1'b1;
            r_done       <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        ST_MM_RST: begin
          if (r_cnt >= C_RST_LAST) begin
            r_rst_mmcm <= 1'b0;
            r_cnt      <= '0;
            r_state    <= ST_MM_LOCK;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        ST_MM_LOCK: begin
          if (i_locked) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (r_cnt >= C_LOCK_LAST) begin
            r_err_lock_tmo <= 1'b1;
            r_done         <= 1'b1;
            r_state        <= ST_IDLE;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        default: begin
          r_rst_mmcm <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase

      for (int i = 0; i < NL; i++) begin
        if (w_lane_we[i]) begin
          r_lane_shadow[i*8 +: 8] <= i_cmd_data;
          r_pend_lane[i]          <= 1'b1;
        end
      end
      if (w_ph_we) begin
        r_ph_shadow <= i_cmd_data;
        r_pend_ph   <= 1'b1;
      end
      if (w_mmcm_we) r_pend_mmcm <= 1'b1;
    end
  end

  assign o_dly_data      = r_dly_data;
  assign o_set_idelay    = r_set_idelay;
  assign o_ld_idelay     = r_ld_idelay;
  assign o_set_clk_phase = r_set_clk_phase;
  assign o_rst_mmcm      = r_rst_mmcm;
  assign o_done          = r_done;
  assign o_err_ps_tmo    = r_err_ps_tmo;
  assign o_err_lock_tmo  = r_err_lock_tmo;
  assign o_pending       = {r_pend_mmcm, r_pend_ph, r_pend_lane};
  assign o_busy          = (r_state != ST_IDLE) || r_pend_mmcm || r_pend_ph || (|r_pend_lane);
  assign o_state         = r_state;

endmodule
